mux_sel_arbiter: RTL and testbench

- Two-requester round-robin arbiter that produces the registered select for the downstream 2:1 multiplexer (i0/i1/s → y).
- Each source raises a request, holds it for the duration of a transfer, and marks the final cycle with a last strobe.
- The arbiter grants one source at a time and drives sel so the mux passes only the granted source.
- A hold limit prevents either source from starving the other.

---
 rtl/mux_sel_arbiter_pkg.sv | 22 ++
 rtl/mux_sel_arbiter_if.sv | 17 +
 rtl/mux_sel_arbiter_hold_counter.sv | 33 +++
 rtl/mux_sel_arbiter.sv | 109 ++++++++++
 tb/tb_mux_sel_arbiter.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/mux_sel_arbiter_pkg.sv
// Shared definitions for the two-source round-robin mux-select arbiter:
// state encoding, mux select polarity and the arbitration rule.
package mux_sel_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } state_e;

  localparam logic SEL_I0 = 1'b0;
  localparam logic SEL_I1 = 1'b1;

  // Round-robin pick: on a tie the source not granted most recently wins.
  function automatic state_e arbitrate(input logic r0, input logic r1, input logic last_was1);
    if (r0 && r1) return last_was1 ? ST_G0 : ST_G1;
    else if (r0)  return ST_G0;
    else if (r1)  return ST_G1;
    else          return ST_IDLE;
  endfunction

endpackage

// File: rtl/mux_sel_arbiter_if.sv
// Request/grant bundle between the two sources and the arbiter.
interface mux_sel_arbiter_if;
  logic req0;
  logic req1;
  logic last0;
  logic last1;
  logic gnt0;
  logic gnt1;
  logic sel;
  logic busy;
  logic forced;

  modport master (output req0, req1, last0, last1,
                  input  gnt0, gnt1, sel, busy, forced);
  modport slave  (input  req0, req1, last0, last1,
                  output gnt0, gnt1, sel, busy, forced);
endinterface

// File: rtl/mux_sel_arbiter_hold_counter.sv
// Saturating grant-hold counter; limit_o flags that the current grant
// has used up its allowance (never asserted when MAX_HOLD is 0).
module mux_sel_arbiter_hold_counter #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic limit_o
);

  localparam logic [CNT_W-1:0] LIMIT = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign limit_o = (MAX_HOLD != 0) && (cnt_q >= LIMIT);

endmodule

// File: rtl/mux_sel_arbiter.sv
// Two-requester round-robin arbiter producing a registered 2:1 mux select,
// with a hold limit that hands the path over when the other source waits.
module mux_sel_arbiter
  import mux_sel_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  mux_sel_arbiter_if.slave   arb
);

  state_e state_q, state_d;
  logic   last1_q, last1_d;
  logic   sel_q, sel_d;
  logic   forced_q, forced_d;

  logic   cnt_clr, cnt_en, limit_hit;
  logic   done, abandon, limit_rel, pick, ptr;

  mux_sel_arbiter_hold_counter #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) u_hold (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .limit_o (limit_hit)
  );

  always_comb begin
    state_d   = state_q;
    last1_d   = last1_q;
    sel_d     = sel_q;
    forced_d  = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    done      = 1'b0;
    abandon   = 1'b0;
    limit_rel = 1'b0;
    pick      = 1'b0;
    ptr       = last1_q;

    case (state_q)
      ST_IDLE: pick = 1'b1;
      ST_G0: begin
        done      = arb.req0 & arb.last0;
        abandon   = ~arb.req0;
        limit_rel = limit_hit & arb.req1;
        ptr       = 1'b0;
        cnt_en    = 1'b1;
      end
      ST_G1: begin
        done      = arb.req1 & arb.last1;
        abandon   = ~arb.req1;
        limit_rel = limit_hit & arb.req0;
        ptr       = 1'b1;
        cnt_en    = 1'b1;
      end
      default: pick = 1'b1;
    endcase

    // A completed or abandoned transfer is a normal release, never a forced one.
    if (done || abandon || limit_rel) begin
      pick     = 1'b1;
      forced_d = limit_rel & ~done & ~abandon;
    end

    if (pick) begin
      state_d = arbitrate(arb.req0, arb.req1, ptr);
      cnt_clr = (state_d != ST_IDLE);
    end

    case (state_d)
      ST_G0: begin
        sel_d   = SEL_I0;
        last1_d = 1'b0;
      end
      ST_G1: begin
        sel_d   = SEL_I1;
        last1_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      last1_q  <= 1'b1;
      sel_q    <= SEL_I0;
      forced_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last1_q  <= last1_d;
      sel_q    <= sel_d;
      forced_q <= forced_d;
    end
  end

  assign arb.gnt0   = (state_q == ST_G0);
  assign arb.gnt1   = (state_q == ST_G1);
  assign arb.sel    = sel_q;
  assign arb.busy   = (state_q == ST_G0) | (state_q == ST_G1);
  assign arb.forced = forced_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter: a cycle table on a MAX_HOLD=4 instance
// plus hand sequences for async reset; a MAX_HOLD=0 instance shares the stimulus.
module tb_mux_sel_arbiter;

  logic clk;
  logic rst;
  logic r0, r1, l0, l1;

  int n_vec = 0;
  int n_err = 0;

  mux_sel_arbiter_if ifa ();
  mux_sel_arbiter_if ifb ();

  assign ifa.req0  = r0;
  assign ifa.req1  = r1;
  assign ifa.last0 = l0;
  assign ifa.last1 = l1;
  assign ifb.req0  = r0;
  assign ifb.req1  = r1;
  assign ifb.last0 = l0;
  assign ifb.last1 = l1;

  mux_sel_arbiter #(.MAX_HOLD(4), .CNT_W(8)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .arb (ifa)
  );

  mux_sel_arbiter #(.MAX_HOLD(0), .CNT_W(8)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .arb (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       r0;
    logic       r1;
    logic       l0;
    logic       l1;
    logic [4:0] exp;   // {gnt0, gnt1, sel, busy, forced}
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rs, input logic a, input logic b,
                     input logic c, input logic d, input logic [4:0] e);
    vec_t v;
    v.rst = rs; v.r0 = a; v.r1 = b; v.l0 = c; v.l1 = d; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [4:0] act, input logic [4:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got {g0,g1,sel,busy,forced}=%b expected %b", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] outs_a();
    return {ifa.gnt0, ifa.gnt1, ifa.sel, ifa.busy, ifa.forced};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      n_vec++;
      if (ifa.gnt0 && ifa.gnt1) begin
        n_err++;
        $display("FAIL excl: gnt0=%b gnt1=%b both high at %0t", ifa.gnt0, ifa.gnt1, $time);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; r0 = 1'b0; r1 = 1'b0; l0 = 1'b0; l1 = 1'b0;

    // req0 alone, last0 with req0 still high re-grants, then abandon
    add(0,1,0,0,0,5'b10010); add(0,1,0,0,0,5'b10010); add(0,1,0,0,0,5'b10010);
    add(0,1,0,0,0,5'b10010); add(0,1,0,1,0,5'b10010);
    add(0,0,0,0,0,5'b00000); add(0,0,0,0,0,5'b00000);
    // reset, then alternation under a standing tie
    add(1,0,0,0,0,5'b00000);
    add(0,1,1,0,0,5'b10010); add(0,1,1,0,0,5'b10010); add(0,1,1,1,0,5'b01110);
    add(0,1,1,0,0,5'b01110); add(0,1,1,0,1,5'b10010); add(0,1,1,1,0,5'b01110);
    add(0,0,0,0,0,5'b00100);
    // hold limit forces handover both ways
    add(0,1,1,0,0,5'b10010); add(0,1,1,0,0,5'b10010); add(0,1,1,0,0,5'b10010);
    add(0,1,1,0,0,5'b10010); add(0,1,1,0,0,5'b01111); add(0,1,1,0,0,5'b01110);
    add(0,1,1,0,0,5'b01110); add(0,1,1,0,0,5'b01110); add(0,1,1,0,0,5'b10011);
    add(0,0,0,0,0,5'b00000);
    // last1 coinciding with the limit is a normal release
    add(0,1,1,0,0,5'b01110); add(0,1,1,0,0,5'b01110); add(0,1,1,0,0,5'b01110);
    add(0,1,1,0,0,5'b01110); add(0,1,1,0,1,5'b10010); add(0,0,0,0,0,5'b00000);
    // req0 alone for 10 cycles never trips the limit
    for (int k = 0; k < 10; k++) add(0,1,0,0,0,5'b10010);
    add(0,0,0,0,0,5'b00000);

    repeat (2) @(posedge clk);
    #1;
    check("reset", outs_a(), 5'b00000);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; r0 = vecs[i].r0; r1 = vecs[i].r1;
      l0 = vecs[i].l0;   l1 = vecs[i].l1;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), outs_a(), vecs[i].exp);
      check($sformatf("nolimit_forced%0d", i), {4'b0000, ifb.forced}, 5'b00000);
    end

    // async reset in G1 mid-transfer
    rst = 1'b0; r0 = 1'b0; r1 = 1'b1; l0 = 1'b0; l1 = 1'b0;
    @(posedge clk);
    #1;
    check("g1_enter", outs_a(), 5'b01110);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", outs_a(), 5'b00000);
    r0 = 1'b1; r1 = 1'b1;
    @(posedge clk);
    #1;
    check("rst_held", outs_a(), 5'b00000);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("tie_after_rst", outs_a(), 5'b10010);

    // req0 dropped without last0
    r1 = 1'b0;
    @(posedge clk);
    #1;
    check("g0_hold", outs_a(), 5'b10010);
    r0 = 1'b0;
    @(posedge clk);
    #1;
    check("abandon_idle", outs_a(), 5'b00000);
    @(posedge clk);
    #1;
    check("idle_stay", outs_a(), 5'b00000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
